// File: rtl/bist_pkg.sv
// Shared types and width helpers for the BIST sequencer family.
package bist_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ARMED      = 3'd1,
    RUN        = 3'd2,
    DONE       = 3'd3,
    DONE_ARMED = 3'd4
  } bist_state_e;

  // Width needed to hold values 0..max_val-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/bist_loop_cnt.sv
// Nested inner/outer loop counter: i runs 0..N (N is the gap slot), r runs 0..M-1.
module bist_loop_cnt
  import bist_pkg::*;
#(
  parameter int unsigned N    = 9,
  parameter int unsigned M    = 9,
  parameter int unsigned CW_N = cnt_width(N + 1),
  parameter int unsigned CW_M = cnt_width(M)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  output logic [CW_M-1:0] r_o,
  output logic            gap_o,
  output logic            last_o
);

  localparam logic [CW_N-1:0] I_MAX = CW_N'(N);
  localparam logic [CW_M-1:0] R_MAX = CW_M'(M - 1);

  logic [CW_N-1:0] i_q, i_d;
  logic [CW_M-1:0] r_q, r_d;
  logic            gap;
  logic            last_round;

  // Compare with >= so any out-of-range value folds back to zero on the next step.
  assign gap        = (i_q >= I_MAX);
  assign last_round = (r_q >= R_MAX);

  always_comb begin
    i_d = i_q;
    r_d = r_q;
    if (clr) begin
      i_d = '0;
      r_d = '0;
    end else if (en) begin
      if (!gap) begin
        i_d = i_q + 1'b1;
      end else begin
        i_d = '0;
        r_d = last_round ? '0 : r_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q <= '0;
      r_q <= '0;
    end else begin
      i_q <= i_d;
      r_q <= r_d;
    end
  end

  assign r_o    = r_q;
  assign gap_o  = gap;
  assign last_o = gap & last_round;

endmodule

// File: rtl/bist_seq_ctrl.sv
// START-handshaked BIST sequencer: M rounds of N active cycles plus one gap, rotating channels per round.
module bist_seq_ctrl
  import bist_pkg::*;
#(
  parameter int unsigned N      = 9,
  parameter int unsigned M      = 9,
  parameter int unsigned NUM_CH = 1,
  parameter int unsigned CW_N   = cnt_width(N + 1),
  parameter int unsigned CW_M   = cnt_width(M)
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic              ABORT,
  input  logic              LOOP,
  output logic [NUM_CH-1:0] OUT,
  output logic              RUNNING,
  output logic              BIST_END,
  output logic              ABORTED,
  output logic [CW_M-1:0]   ROUND
);

  bist_state_e     state_q, state_d;
  logic            aborted_q, aborted_d;
  logic            cnt_clr;
  logic            cnt_en;
  logic [CW_M-1:0] r;
  logic            gap;
  logic            last_gap;
  logic            launch;

  bist_loop_cnt #(
    .N    (N),
    .M    (M),
    .CW_N (CW_N),
    .CW_M (CW_M)
  ) u_loop_cnt (
    .clk    (CLK),
    .rst_n  (RESET_N),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .r_o    (r),
    .gap_o  (gap),
    .last_o (last_gap)
  );

  assign launch = START && ((state_q == ARMED) || (state_q == DONE_ARMED));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (!START) state_d = ARMED;
      ARMED:      if (START) state_d = RUN;
      RUN:        if (ABORT || (last_gap && !LOOP)) state_d = DONE;
      DONE:       if (!START) state_d = DONE_ARMED;
      DONE_ARMED: if (START) state_d = RUN;
      default:    state_d = IDLE;
    endcase
  end

  // Counters are held cleared outside RUN, so every launch starts at i=0, r=0.
  always_comb begin
    cnt_clr   = (state_q != RUN) || ABORT;
    cnt_en    = (state_q == RUN);
    aborted_d = aborted_q;
    if ((state_q == RUN) && ABORT) begin
      aborted_d = 1'b1;
    end else if (launch) begin
      aborted_d = 1'b0;
    end
  end

  always_comb begin
    OUT      = '0;
    RUNNING  = 1'b0;
    BIST_END = 1'b0;
    ABORTED  = 1'b0;
    ROUND    = '0;
    case (state_q)
      IDLE, ARMED: begin
        ABORTED = aborted_q;
      end
      RUN: begin
        RUNNING = 1'b1;
        ABORTED = aborted_q;
        ROUND   = r;
        if (!gap) begin
          for (int unsigned c = 0; c < NUM_CH; c++) begin
            OUT[c] = (c == (int'(r) % NUM_CH));
          end
        end
      end
      DONE, DONE_ARMED: begin
        BIST_END = 1'b1;
        ABORTED  = aborted_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bist_seq_ctrl.sv
// Bench for bist_seq_ctrl: two configurations share stimulus and are checked against a run-cycle model.
module tb_bist_seq_ctrl;

  logic       CLK;
  logic       RESET_N;
  logic       START;
  logic       ABORT;
  logic       LOOP;

  logic [0:0] a_out;
  logic       a_running, a_bist_end, a_aborted;
  logic [3:0] a_round;
  logic [1:0] b_out;
  logic       b_running, b_bist_end, b_aborted;
  logic [1:0] b_round;

  bist_seq_ctrl #(.N(9), .M(9), .NUM_CH(1)) u_a (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .ABORT(ABORT), .LOOP(LOOP),
    .OUT(a_out), .RUNNING(a_running), .BIST_END(a_bist_end), .ABORTED(a_aborted), .ROUND(a_round)
  );

  bist_seq_ctrl #(.N(3), .M(4), .NUM_CH(2)) u_b (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .ABORT(ABORT), .LOOP(LOOP),
    .OUT(b_out), .RUNNING(b_running), .BIST_END(b_bist_end), .ABORTED(b_aborted), .ROUND(b_round)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_chk;
  int n_fail;
  bit chk_on;

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: mode plus a single run-cycle index k; outputs follow from k by division.
  typedef enum {M_IDLE, M_ARMED, M_RUN, M_DONE, M_DARM} mmode_e;
  int unsigned pn[2] = '{9, 3};
  int unsigned pm[2] = '{9, 4};
  int unsigned pc[2] = '{1, 2};
  mmode_e      mm[2];
  int unsigned mk[2];
  bit          mab[2];

  function automatic int unsigned run_len(input int d);
    return pm[d] * (pn[d] + 1);
  endfunction

  function automatic bit launching(input int d);
    return ((mm[d] == M_ARMED) || (mm[d] == M_DARM)) && (START == 1'b1);
  endfunction

  function automatic mmode_e nx_mode(input int d);
    case (mm[d])
      M_IDLE:  return START ? M_IDLE : M_ARMED;
      M_ARMED: return START ? M_RUN : M_ARMED;
      M_RUN:   return (ABORT || ((mk[d] + 1 == run_len(d)) && !LOOP)) ? M_DONE : M_RUN;
      M_DONE:  return START ? M_DONE : M_DARM;
      default: return START ? M_RUN : M_DARM;
    endcase
  endfunction

  function automatic int unsigned nx_k(input int d);
    if (mm[d] != M_RUN || ABORT) return 0;
    return (mk[d] + 1) % run_len(d);
  endfunction

  function automatic bit nx_ab(input int d);
    if (mm[d] == M_RUN && ABORT) return 1'b1;
    if (launching(d)) return 1'b0;
    return mab[d];
  endfunction

  always @(posedge CLK or negedge RESET_N) begin
    for (int d = 0; d < 2; d++) begin
      if (!RESET_N) begin
        mm[d]  <= M_IDLE;
        mk[d]  <= 0;
        mab[d] <= 1'b0;
      end else begin
        mm[d]  <= nx_mode(d);
        mk[d]  <= nx_k(d);
        mab[d] <= nx_ab(d);
      end
    end
  end

  function automatic int unsigned e_out(input int d);
    int unsigned p;
    int unsigned rr;
    p  = mk[d] % (pn[d] + 1);
    rr = mk[d] / (pn[d] + 1);
    if (mm[d] != M_RUN || p == pn[d]) return 0;
    return 1 << (rr % pc[d]);
  endfunction

  function automatic int unsigned e_round(input int d);
    return (mm[d] == M_RUN) ? mk[d] / (pn[d] + 1) : 0;
  endfunction

  function automatic int unsigned e_run(input int d);
    return (mm[d] == M_RUN) ? 1 : 0;
  endfunction

  function automatic int unsigned e_end(input int d);
    return (mm[d] == M_DONE || mm[d] == M_DARM) ? 1 : 0;
  endfunction

  always @(negedge CLK) begin
    if (chk_on) begin
      chk("A_OUT", a_out, e_out(0));
      chk("A_RUNNING", a_running, e_run(0));
      chk("A_BIST_END", a_bist_end, e_end(0));
      chk("A_ABORTED", a_aborted, mab[0]);
      chk("A_ROUND", a_round, e_round(0));
      chk("B_OUT", b_out, e_out(1));
      chk("B_RUNNING", b_running, e_run(1));
      chk("B_BIST_END", b_bist_end, e_end(1));
      chk("B_ABORTED", b_aborted, mab[1]);
      chk("B_ROUND", b_round, e_round(1));
    end
  end

  localparam int unsigned EXP_B_OUT[16] = '{1, 1, 1, 0, 2, 2, 2, 0, 1, 1, 1, 0, 2, 2, 2, 0};
  localparam int unsigned EXP_B_RND[16] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3};

  int unsigned bq[$];
  int unsigned rq[$];

  task automatic launch();
    START = 1'b0;
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
  endtask

  task automatic run_until_end(input int unsigned budget, output int unsigned rc, output int unsigned oc);
    rc = 0;
    oc = 0;
    bq.delete();
    rq.delete();
    for (int unsigned t = 0; t < budget && !a_bist_end; t++) begin
      if (a_running) rc++;
      if (a_out != 0) oc++;
      if (b_running) begin
        bq.push_back(int'(b_out));
        rq.push_back(int'(b_round));
      end
      @(negedge CLK);
    end
    chk("A_BIST_END_REACHED", a_bist_end, 1);
  endtask

  initial begin
    int unsigned rc, oc, prev;
    bit end_seen, wrap_seen;
    n_chk = 0; n_fail = 0; chk_on = 1'b0;
    RESET_N = 1'b1; START = 1'b1; ABORT = 1'b0; LOOP = 1'b0;
    #2 RESET_N = 1'b0;
    #1 chk_on = 1'b1;
    chk("RST_A_OUT", a_out, 0);
    chk("RST_A_RUNNING", a_running, 0);
    chk("RST_A_BIST_END", a_bist_end, 0);
    chk("RST_A_ABORTED", a_aborted, 0);
    chk("RST_A_ROUND", a_round, 0);
    chk("RST_B_OUT", b_out, 0);
    repeat (3) @(negedge CLK);
    @(posedge CLK);
    #3 RESET_N = 1'b1;

    // START held high out of reset must not launch
    repeat (6) @(negedge CLK);
    chk("HELD_START_RUNNING", a_running, 0);
    chk("HELD_START_BIST_END", a_bist_end, 0);
    chk("HELD_START_OUT", a_out, 0);

    // Normal run on both configurations
    launch();
    chk("LAUNCH_RUNNING", a_running, 1);
    run_until_end(300, rc, oc);
    chk("A_RUN_CYCLES", rc, 90);
    chk("A_OUT_CYCLES", oc, 81);
    chk("A_ABORTED_NORMAL", a_aborted, 0);
    chk("A_RUNNING_AFTER_END", a_running, 0);
    chk("B_RUN_LEN", bq.size(), 16);
    for (int j = 0; j < 16 && j < bq.size(); j++) begin
      chk("B_OUT_SEQ", bq[j], EXP_B_OUT[j]);
      chk("B_ROUND_SEQ", rq[j], EXP_B_RND[j]);
    end

    // START still high in DONE: no relaunch
    repeat (5) @(negedge CLK);
    chk("DONE_HOLD_RUNNING", a_running, 0);
    chk("DONE_HOLD_BIST_END", a_bist_end, 1);

    // Abort at running cycle 25, then relaunch
    launch();
    repeat (24) @(negedge CLK);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    chk("ABORT_RUNNING", a_running, 0);
    chk("ABORT_BIST_END", a_bist_end, 1);
    chk("ABORT_ABORTED", a_aborted, 1);
    launch();
    chk("RELAUNCH_ABORTED_CLR", a_aborted, 0);
    run_until_end(300, rc, oc);
    chk("RELAUNCH_RUN_CYCLES", rc, 90);

    // Continuous mode
    LOOP = 1'b1;
    launch();
    end_seen = 1'b0;
    wrap_seen = 1'b0;
    prev = a_round;
    for (int t = 0; t < 200; t++) begin
      if (prev == 8 && a_round == 0) wrap_seen = 1'b1;
      if (a_bist_end) end_seen = 1'b1;
      prev = a_round;
      @(negedge CLK);
    end
    chk("LOOP_STILL_RUNNING", a_running, 1);
    chk("LOOP_NO_BIST_END", end_seen, 0);
    chk("LOOP_ROUND_WRAP", wrap_seen, 1);
    LOOP = 1'b0;
    run_until_end(300, rc, oc);
    chk("LOOP_TOTAL_CYCLES", 200 + rc, 270);

    // Asynchronous reset mid-run
    launch();
    repeat (30) @(negedge CLK);
    @(posedge CLK);
    #3 RESET_N = 1'b0;
    #1;
    chk("ARST_A_OUT", a_out, 0);
    chk("ARST_A_RUNNING", a_running, 0);
    chk("ARST_A_ROUND", a_round, 0);
    chk("ARST_B_RUNNING", b_running, 0);
    repeat (2) @(negedge CLK);
    @(posedge CLK);
    #3 RESET_N = 1'b1;
    repeat (5) @(negedge CLK);
    chk("ARST_HELD_START_RUNNING", a_running, 0);
    chk("ARST_HELD_START_BIST_END", a_bist_end, 0);
    launch();
    chk("ARST_RELAUNCH_RUNNING", a_running, 1);
    run_until_end(300, rc, oc);
    chk("ARST_RELAUNCH_CYCLES", rc, 90);

    // Random traffic, checked every cycle by the model
    for (int t = 0; t < 1500; t++) begin
      @(negedge CLK);
      if ($urandom_range(0, 7) == 0) START = ~START;
      ABORT = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 59) == 0) LOOP = ~LOOP;
    end

    repeat (2) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
